// File: rtl/router_pkg.sv
// router_pkg: shared sizes, header field bounds and the stored FIFO entry type.
// Provides ROUTER_DEPTH, ROUTER_WIDTH, HDR_LEN_*, HDR_ADDR_* and fifo_entry_t.
package router_pkg;
   localparam int ROUTER_DEPTH = 16;
   localparam int ROUTER_WIDTH = 8;
   localparam int HDR_LEN_MSB  = 7;
   localparam int HDR_LEN_LSB  = 2;
   localparam int HDR_ADDR_MSB = 1;
   localparam int HDR_ADDR_LSB = 0;
   typedef struct packed {
      logic                    hdr;
      logic [ROUTER_WIDTH-1:0] data;
   } fifo_entry_t;
endpackage

// File: rtl/router_fifo_mem.sv
// router_fifo_mem: dual-port register array, synchronous write, asynchronous read, no reset.
// Ports: i_clk clock; i_we/i_waddr/i_wdata write port; i_raddr/o_rdata read port.
module router_fifo_mem
   import router_pkg::*;
#(
   parameter int DEPTH = ROUTER_DEPTH,
   parameter int WIDTH = ROUTER_WIDTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [WIDTH:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [WIDTH:0] o_rdata
);
   logic [WIDTH:0] r_mem [DEPTH];
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end
   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/router_fifo.sv
// router_fifo: per-destination packet buffer with header marker and packet byte counter.
// Ports: i_clk, i_rst_n (async active-low); i_soft_reset sync flush; i_write_enb/i_lfd_state/
// i_data_in write side; i_read_enb/o_data_out read side; o_full, o_empty status; o_pkt_done
// pulse after the last byte of a packet is read. Macro ROUTER_FIFO_OVF_FLAG_EN adds a sticky
// o_overflow_err raised by writes attempted while full.
module router_fifo
   import router_pkg::*;
#(
   parameter int DEPTH = ROUTER_DEPTH,
   parameter int WIDTH = ROUTER_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_soft_reset,
   input  logic             i_write_enb,
   input  logic             i_read_enb,
   input  logic             i_lfd_state,
   input  logic [WIDTH-1:0] i_data_in,
   output logic [WIDTH-1:0] o_data_out,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_pkt_done
`ifdef ROUTER_FIFO_OVF_FLAG_EN
   ,output logic            o_overflow_err
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
   logic [AW:0]    r_wr_ptr, r_rd_ptr;
   logic [6:0]     r_cnt;
   logic [WIDTH:0] w_rd_entry;
   logic           w_wr, w_rd;
   assign o_empty = r_wr_ptr == r_rd_ptr;
   assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   // flush wins over any same-cycle access, so the write never lands in storage
   assign w_wr = i_write_enb && !o_full && !i_soft_reset;
   assign w_rd = i_read_enb && !o_empty;
   router_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
      .i_clk  (i_clk),
      .i_we   (w_wr),
      .i_waddr(r_wr_ptr[AW-1:0]),
      .i_wdata({i_lfd_state, i_data_in}),
      .i_raddr(r_rd_ptr[AW-1:0]),
      .o_rdata(w_rd_entry)
   );
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_cnt      <= '0;
         o_data_out <= '0;
         o_pkt_done <= 1'b0;
      end else if (i_soft_reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_cnt      <= '0;
         o_data_out <= '0;
         o_pkt_done <= 1'b0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_rd) begin
            r_rd_ptr   <= r_rd_ptr + PTR_ONE;
            o_data_out <= w_rd_entry[WIDTH-1:0];
            // header carries payload length; +1 accounts for the trailing parity byte
            if (w_rd_entry[WIDTH]) r_cnt <= 7'(w_rd_entry[WIDTH-1:HDR_LEN_LSB]) + 7'd1;
            else if (r_cnt != 7'd0) r_cnt <= r_cnt - 7'd1;
         end
         o_pkt_done <= w_rd && !w_rd_entry[WIDTH] && (r_cnt == 7'd1);
      end
   end
`ifdef ROUTER_FIFO_OVF_FLAG_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_overflow_err <= 1'b0;
      else if (i_soft_reset) o_overflow_err <= 1'b0;
      else if (i_write_enb && o_full) o_overflow_err <= 1'b1;
   end
`endif
endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: directed scoreboard bench for router_fifo.
module tb_router_fifo;
   import router_pkg::*;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       soft_reset = 1'b0, write_enb = 1'b0, read_enb = 1'b0, lfd_state = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       full, empty, pkt_done;
`ifdef ROUTER_FIFO_OVF_FLAG_EN
   logic       overflow_err;
`endif
   int compared = 0;
   int mismatched = 0;
   fifo_entry_t q[$];
   logic [7:0] m_dout = 8'h00;
   logic [6:0] m_cnt = 7'd0;
   logic       m_pd = 1'b0;
   logic       m_ovf = 1'b0;

   router_fifo dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_soft_reset(soft_reset),
      .i_write_enb (write_enb),
      .i_read_enb  (read_enb),
      .i_lfd_state (lfd_state),
      .i_data_in   (data_in),
      .o_data_out  (data_out),
      .o_full      (full),
      .o_empty     (empty),
      .o_pkt_done  (pkt_done)
`ifdef ROUTER_FIFO_OVF_FLAG_EN
      ,.o_overflow_err(overflow_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "_dout"}, data_out, m_dout);
      chk({tag, "_empty"}, empty, q.size() == 0);
      chk({tag, "_full"}, full, q.size() == 16);
      chk({tag, "_pkt_done"}, pkt_done, m_pd);
`ifdef ROUTER_FIFO_OVF_FLAG_EN
      chk({tag, "_ovf"}, overflow_err, m_ovf);
`endif
   endtask

   task automatic model_clear();
      q.delete();
      m_dout = 8'h00;
      m_cnt  = 7'd0;
      m_pd   = 1'b0;
      m_ovf  = 1'b0;
   endtask

   // one clock: drive, let the edge happen, advance the model, compare
   task automatic cyc(input string tag, input logic sr, input logic we, input logic re,
                      input logic lfd, input logic [7:0] din);
      logic fm, em, pd_n;
      fifo_entry_t e;
      fm = q.size() == 16;
      em = q.size() == 0;
      soft_reset = sr; write_enb = we; read_enb = re; lfd_state = lfd; data_in = din;
      @(posedge clk);
      if (sr) model_clear();
      else begin
         pd_n = 1'b0;
         if (re && !em) begin
            e = q.pop_front();
            m_dout = e.data;
            if (e.hdr) m_cnt = 7'(e.data[7:2]) + 7'd1;
            else if (m_cnt != 7'd0) begin
               pd_n  = m_cnt == 7'd1;
               m_cnt = m_cnt - 7'd1;
            end
         end
         if (we && !fm) q.push_back('{hdr: lfd, data: din});
         if (we && fm) m_ovf = 1'b1;
         m_pd = pd_n;
      end
      #1;
      soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0;
      chk_all(tag);
   endtask

   task automatic wr(input string tag, input logic lfd, input logic [7:0] din);
      cyc(tag, 1'b0, 1'b1, 1'b0, lfd, din);
   endtask

   task automatic rd(input string tag);
      cyc(tag, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
   endtask

   logic [7:0] pkt [5] = '{8'h0E, 8'h11, 8'h22, 8'h33, 8'h5A};

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_dout", data_out, 8'h00);
      chk("rst_pkt_done", pkt_done, 1'b0);
`ifdef ROUTER_FIFO_OVF_FLAG_EN
      chk("rst_ovf", overflow_err, 1'b0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      // packet round trip
      for (int i = 0; i < 5; i++) wr("pkt_wr", i == 0, pkt[i]);
      for (int i = 0; i < 5; i++) begin
         rd("pkt_rd");
         chk("pkt_byte", data_out, pkt[i]);
         chk("pkt_done_at", pkt_done, i == 4);
      end
      cyc("pkt_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("pkt_done_clr", pkt_done, 1'b0);
      // full and dropped 17th write
      for (int i = 0; i < 17; i++) begin
         wr("fill", 1'b0, 8'h40 + 8'(i));
         chk("fill_full", full, i >= 15);
      end
      for (int i = 0; i < 16; i++) begin
         rd("drain");
         chk("drain_byte", data_out, 8'h40 + 8'(i));
      end
      chk("drain_empty", empty, 1'b1);
      // simultaneous access at 15, 16 and 0 entries
      for (int i = 0; i < 15; i++) wr("sim_fill", 1'b0, 8'h80 + 8'(i));
      cyc("sim15", 1'b0, 1'b1, 1'b1, 1'b0, 8'h8F);
      chk("sim15_full", full, 1'b0);
      wr("sim_top", 1'b0, 8'h90);
      chk("sim16_pre_full", full, 1'b1);
      cyc("sim16", 1'b0, 1'b1, 1'b1, 1'b0, 8'hEE);
      chk("sim16_full", full, 1'b0);
      for (int i = 0; i < 15; i++) rd("sim_drain");
      chk("sim_drain_empty", empty, 1'b1);
      cyc("sim0", 1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
      chk("sim0_dout", data_out, 8'h90);
      chk("sim0_empty", empty, 1'b0);
      rd("sim0_rd");
      chk("sim0_byte", data_out, 8'h77);
      // soft reset with concurrent read
      for (int i = 0; i < 6; i++) wr("sr_fill", 1'b0, 8'hC0 + 8'(i));
      cyc("sr", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("sr_empty", empty, 1'b1);
      chk("sr_dout", data_out, 8'h00);
      wr("sr_wr", 1'b0, 8'hA5);
      rd("sr_rd");
      chk("sr_byte", data_out, 8'hA5);
      // wrap-around
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 10; i++) wr("wrap_wr", 1'b0, 8'(r * 10 + i + 1));
         for (int i = 0; i < 10; i++) begin
            rd("wrap_rd");
            chk("wrap_byte", data_out, 8'(r * 10 + i + 1));
         end
      end
      // asynchronous reset mid-packet
      wr("ar_wr", 1'b1, 8'h08);
      wr("ar_wr", 1'b0, 8'h01);
      wr("ar_wr", 1'b0, 8'h02);
      rd("ar_rd");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_clear();
      chk("ar_dout", data_out, 8'h00);
      chk("ar_empty", empty, 1'b1);
      chk("ar_full", full, 1'b0);
      chk("ar_pkt_done", pkt_done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      wr("ar_after_wr", 1'b0, 8'h3C);
      rd("ar_after_rd");
      chk("ar_after_byte", data_out, 8'h3C);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
